otter_mmio_timer: RTL and testbench
===================================

# otter_mmio_timer

Memory-mapped timer/counter peripheral on the OTTER IOBUS, placed beside the switch/LED/seven-segment MMIO decode in the board wrapper. It decodes CPU writes from the IOBUS, runs a prescaled 32-bit up-counter with compare match, and returns register reads on a combinational data output that the wrapper's input mux routes onto IOBUS_in. A compare match raises a level interrupt toward the CPU.

## Interface
- BASE_AD, 32'h11000060: base address of the register block; word offsets +0x0 CTRL, +0x4 STATUS, +0x8 PRESCALE, +0xC CMP, +0x10 COUNT.
- CLK  in  1  system clock (the 50 MHz CPU clock); all state on rising edge.
- RST  in  1  reset; asynchronous, active-high; clears every register.
- IOBUS_ADDR  in  32  CPU bus address.
- IOBUS_OUT  in  32  CPU write data.
- IOBUS_WR  in  1  write strobe; a write occurs on the CLK edge when high and IOBUS_ADDR matches a register.
- RD_DATA  out  32  combinational read data for IOBUS_ADDR; 0 when the address matches no register.
- INTR  out  1  registered interrupt level = STATUS.MATCH & CTRL.IE.

## Operation
- CTRL: [0] EN, [1] AUTO (auto-reload), [2] IE; other bits read 0, ignored on write.
- STATUS: [0] MATCH, sticky; writing 1 clears it, writing 0 has no effect.
- PRESCALE [15:0], CMP [31:0], COUNT [31:0] are read/write; upper PRESCALE bits read 0.
- Internal prescale counter pre_cnt (16 bit), not visible on the bus.
- Each cycle with EN=1: if pre_cnt == PRESCALE then pre_cnt <= 0 and tick=1; else pre_cnt <= pre_cnt+1. EN=0: pre_cnt holds, no ticks.
- On tick: if COUNT == CMP then MATCH <= 1, and COUNT <= 0 if AUTO=1, or COUNT holds and EN <= 0 if AUTO=0 (one-shot). Otherwise COUNT <= COUNT+1, wrapping 0xFFFFFFFF -> 0 silently.
- Match period is therefore (CMP+1)*(PRESCALE+1) cycles with AUTO=1.
- A CPU write to COUNT or PRESCALE also clears pre_cnt.
- Simultaneous events: a CPU write to COUNT/CTRL wins over the hardware update in the same cycle. A hardware MATCH set wins over a W1C clear in the same cycle.
- Writes to unmapped addresses (including BASE_AD+0x14 and above, and misaligned offsets) are ignored.
- Reset mid-count: all registers, pre_cnt and INTR go to 0 immediately; the counter stays idle until software sets EN.

## Timing
- Reset values: CTRL=0, STATUS=0, PRESCALE=0, CMP=0, COUNT=0, INTR=0; RD_DATA reflects these (0).
- Register writes take effect at the CLK edge where IOBUS_WR=1; the new value is readable on RD_DATA the following cycle.
- RD_DATA is purely combinational from IOBUS_ADDR and register state: zero-cycle read latency.
- With EN written at edge E and PRESCALE=N, the first tick is at edge E+N+1.
- MATCH sets on the tick edge; INTR rises one edge later. After a W1C clear at edge C, INTR falls at C+1.
- Clearing IE drops INTR one edge later without clearing MATCH.

## Configuration
- OTTER_TIMER_PRESCALE_EN defined: the prescaler is implemented as described.
- Undefined: no pre_cnt or PRESCALE storage; tick=EN every cycle; PRESCALE reads 0 and writes are ignored.

## Test plan
- Reset: assert RST mid-count with COUNT=0x25 -> all reads return 0, INTR=0 immediately and after release.
- Auto-reload: PRESCALE=0, CMP=3, CTRL=0x7 -> COUNT sequence 1,2,3,0 repeating; MATCH every 4 cycles; INTR high one cycle after the first match.
- Prescale: PRESCALE=4, CMP=1, CTRL=0x1 -> COUNT increments every 5 cycles; MATCH at the 10th cycle after enable; one-shot clears EN, COUNT holds at 1.
- W1C race: write STATUS=1 on the same edge a match occurs -> MATCH stays 1; a later write of 1 without a match clears it and INTR drops next cycle.
- Write priority/wrap: COUNT=0xFFFFFFFF, CMP=5, PRESCALE=0, EN=1 -> COUNT wraps to 0; a CPU write COUNT=0x10 on a tick edge yields 0x10.
- Decode: write 0xDEAD to BASE_AD+0x14 and to 0x11000020 -> no register changes; RD_DATA=0 for those addresses.

Source files
------------

// File: rtl/otter_mmio_timer_if.sv
// IOBUS-side signal bundle for the OTTER MMIO timer.
// The CPU/wrapper side is the master, the timer peripheral is the slave.
`timescale 1ns/1ps
interface otter_mmio_timer_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] RD_DATA;
    logic        INTR;

    modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR,
                    input  RD_DATA,    input  INTR);
    modport slave  (input  IOBUS_ADDR, input  IOBUS_OUT, input  IOBUS_WR,
                    output RD_DATA,    output INTR);
endinterface

// File: rtl/otter_mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match and level interrupt.
// Define OTTER_TIMER_PRESCALE_EN to build the prescaler; otherwise it ticks every enabled cycle.
`timescale 1ns/1ps
module otter_mmio_timer #(
    parameter logic [31:0] BASE_AD = 32'h1100_0060
) (
    input  logic              CLK,
    input  logic              RST,
    otter_mmio_timer_if.slave bus
);
    logic        r_en;
    logic        r_auto;
    logic        r_ie;
    logic        r_match;
    logic        r_intr;
    logic [31:0] r_cmp;
    logic [31:0] r_count;

    logic        w_sel_ctrl;
    logic        w_sel_status;
    logic        w_sel_prescale;
    logic        w_sel_cmp;
    logic        w_sel_count;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_wr_cmp;
    logic        w_wr_count;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_prescale_rd;
    logic [31:0] w_rd_data;

    // Exact word-address match: misaligned or out-of-range offsets select nothing.
    assign w_sel_ctrl     = (bus.IOBUS_ADDR == (BASE_AD + 32'h0000_0000));
    assign w_sel_status   = (bus.IOBUS_ADDR == (BASE_AD + 32'h0000_0004));
    assign w_sel_prescale = (bus.IOBUS_ADDR == (BASE_AD + 32'h0000_0008));
    assign w_sel_cmp      = (bus.IOBUS_ADDR == (BASE_AD + 32'h0000_000C));
    assign w_sel_count    = (bus.IOBUS_ADDR == (BASE_AD + 32'h0000_0010));

    assign w_wr_ctrl   = bus.IOBUS_WR & w_sel_ctrl;
    assign w_wr_status = bus.IOBUS_WR & w_sel_status;
    assign w_wr_cmp    = bus.IOBUS_WR & w_sel_cmp;
    assign w_wr_count  = bus.IOBUS_WR & w_sel_count;

`ifdef OTTER_TIMER_PRESCALE_EN
    logic [15:0] r_prescale;
    logic [15:0] r_pre_cnt;
    logic        w_wr_prescale;

    assign w_wr_prescale = bus.IOBUS_WR & w_sel_prescale;
    assign w_tick        = r_en & (r_pre_cnt == r_prescale);
    assign w_prescale_rd = {16'h0000, r_prescale};

    // Prescaler divider; any write to COUNT or PRESCALE restarts the divide phase.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_prescale <= 16'h0000;
            r_pre_cnt  <= 16'h0000;
        end else begin
            if (w_wr_prescale) begin
                r_prescale <= bus.IOBUS_OUT[15:0];
            end
            if (w_wr_prescale | w_wr_count) begin
                r_pre_cnt <= 16'h0000;
            end else if (w_tick) begin
                r_pre_cnt <= 16'h0000;
            end else if (r_en) begin
                r_pre_cnt <= r_pre_cnt + 16'h0001;
            end
        end
    end
`else
    assign w_tick        = r_en;
    assign w_prescale_rd = 32'h0000_0000;
`endif

    assign w_hit = w_tick & (r_count == r_cmp);

    // Control, counter and status state; CPU writes to CTRL/COUNT override hardware updates.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_ie    <= 1'b0;
            r_match <= 1'b0;
            r_intr  <= 1'b0;
            r_cmp   <= 32'h0000_0000;
            r_count <= 32'h0000_0000;
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= bus.IOBUS_OUT[0];
                r_auto <= bus.IOBUS_OUT[1];
                r_ie   <= bus.IOBUS_OUT[2];
            end else if (w_hit & ~r_auto) begin
                r_en <= 1'b0;
            end

            if (w_wr_count) begin
                r_count <= bus.IOBUS_OUT;
            end else if (w_hit) begin
                r_count <= r_auto ? 32'h0000_0000 : r_count;
            end else if (w_tick) begin
                r_count <= r_count + 32'h0000_0001;
            end

            // A match on this edge beats a simultaneous write-one-to-clear.
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_wr_status & bus.IOBUS_OUT[0]) begin
                r_match <= 1'b0;
            end

            if (w_wr_cmp) begin
                r_cmp <= bus.IOBUS_OUT;
            end

            r_intr <= r_match & r_ie;
        end
    end

    // Zero-latency read mux; unmapped addresses return 0.
    always_comb begin
        w_rd_data = 32'h0000_0000;
        if (w_sel_ctrl) begin
            w_rd_data = {29'h0000_0000, r_ie, r_auto, r_en};
        end else if (w_sel_status) begin
            w_rd_data = {31'h0000_0000, r_match};
        end else if (w_sel_prescale) begin
            w_rd_data = w_prescale_rd;
        end else if (w_sel_cmp) begin
            w_rd_data = r_cmp;
        end else if (w_sel_count) begin
            w_rd_data = r_count;
        end else begin
            w_rd_data = 32'h0000_0000;
        end
    end

    assign bus.RD_DATA = w_rd_data;
    assign bus.INTR    = r_intr;
endmodule

// File: tb/tb_otter_mmio_timer.sv
// Self-checking bench for otter_mmio_timer: directed scenarios plus random traffic
// compared against a behavioural model of the register block.
`timescale 1ns/1ps
module tb_otter_mmio_timer;
    localparam logic [31:0] A_CTRL = 32'h1100_0060;
    localparam logic [31:0] A_STAT = 32'h1100_0064;
    localparam logic [31:0] A_PRE  = 32'h1100_0068;
    localparam logic [31:0] A_CMP  = 32'h1100_006C;
    localparam logic [31:0] A_CNT  = 32'h1100_0070;

    logic CLK = 1'b0;
    logic RST;
    otter_mmio_timer_if bus();

    otter_mmio_timer dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #10 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] reg_addr [5] = '{A_CTRL, A_STAT, A_PRE, A_CMP, A_CNT};

    // behavioural model state
    logic        m_en, m_auto, m_ie, m_match, m_intr;
    logic [15:0] m_pre, m_prescale;
    logic [31:0] m_cmp, m_count;

    function automatic void model_reset();
        m_en = 1'b0; m_auto = 1'b0; m_ie = 1'b0; m_match = 1'b0; m_intr = 1'b0;
        m_pre = 16'd0; m_prescale = 16'd0; m_cmp = 32'd0; m_count = 32'd0;
    endfunction

    function automatic void model_step(input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic tick, hit;
        tick = m_en && (m_pre == m_prescale);
        hit  = tick && (m_count == m_cmp);
        m_intr = m_match && m_ie;
        if (wr && (a == A_CNT || a == A_PRE)) m_pre = 16'd0;
        else if (m_en) m_pre = tick ? 16'd0 : 16'(m_pre + 16'd1);
        if (wr && a == A_CNT) m_count = d;
        else if (hit) m_count = m_auto ? 32'd0 : m_count;
        else if (tick) m_count = m_count + 32'd1;
        if (hit) m_match = 1'b1;
        else if (wr && a == A_STAT && d[0]) m_match = 1'b0;
        if (hit && !m_auto) m_en = 1'b0;
        if (wr && a == A_CTRL) begin
            m_en = d[0]; m_auto = d[1]; m_ie = d[2];
        end
        if (wr && a == A_CMP) m_cmp = d;
`ifdef OTTER_TIMER_PRESCALE_EN
        if (wr && a == A_PRE) m_prescale = d[15:0];
`endif
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        case (a)
            A_CTRL:  return {29'd0, m_ie, m_auto, m_en};
            A_STAT:  return {31'd0, m_match};
            A_PRE:   return {16'd0, m_prescale};
            A_CMP:   return m_cmp;
            A_CNT:   return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive at the falling edge, model advances at the rising edge.
    task automatic cycle(input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.IOBUS_WR = wr; bus.IOBUS_ADDR = a; bus.IOBUS_OUT = d;
        @(posedge CLK);
        model_step(wr, a, d);
        @(negedge CLK);
        bus.IOBUS_WR = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.IOBUS_ADDR = a;
        #1;
        v = bus.RD_DATA;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        for (int i = 0; i < 5; i++) begin
            rd(reg_addr[i], got); n_total++;
            if (got !== 32'd0) $display("FAIL reset_por reg %h: got %h expected %h", reg_addr[i], got, 32'd0);
            else n_pass++;
        end
        cycle(1'b1, A_CNT, 32'h25);
        cycle(1'b1, A_CTRL, 32'h1);
        cycle(1'b0, A_CTRL, 32'h0);
        cycle(1'b0, A_CTRL, 32'h0);
        RST = 1'b1;
        model_reset();
        #1;
        n_total++;
        if (bus.INTR !== 1'b0) $display("FAIL reset_intr: got %b expected 0", bus.INTR);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            rd(reg_addr[i], got); n_total++;
            if (got !== 32'd0) $display("FAIL reset_mid reg %h: got %h expected %h", reg_addr[i], got, 32'd0);
            else n_pass++;
        end
        @(negedge CLK);
        RST = 1'b0;
        cycle(1'b0, A_CTRL, 32'h0);
        cycle(1'b0, A_CTRL, 32'h0);
        rd(A_CNT, got); n_total++;
        if (got !== 32'd0 || bus.INTR !== 1'b0) $display("FAIL reset_idle: got count %h intr %b expected 0 0", got, bus.INTR);
        else n_pass++;
    endtask

    task automatic test_auto_reload();
        logic [31:0] got;
        cycle(1'b1, A_PRE, 32'h0);
        cycle(1'b1, A_CMP, 32'h3);
        cycle(1'b1, A_CNT, 32'h0);
        cycle(1'b1, A_CTRL, 32'h7);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, A_CTRL, 32'h0);
            rd(A_CNT, got); n_total++;
            if (got !== 32'((i + 1) % 4)) $display("FAIL auto_count[%0d]: got %h expected %h", i, got, 32'((i + 1) % 4));
            else n_pass++;
            rd(A_STAT, got); n_total++;
            if (got !== mread(A_STAT) || bus.INTR !== m_intr)
                $display("FAIL auto_status[%0d]: got %h/%b expected %h/%b", i, got, bus.INTR, mread(A_STAT), m_intr);
            else n_pass++;
        end
        cycle(1'b1, A_CTRL, 32'h0);
        cycle(1'b1, A_STAT, 32'h1);
    endtask

    task automatic test_prescale();
        logic [31:0] got;
        logic exp_match;
        cycle(1'b1, A_PRE, 32'h4);
        cycle(1'b1, A_CMP, 32'h1);
        cycle(1'b1, A_CNT, 32'h0);
        cycle(1'b1, A_STAT, 32'h1);
        cycle(1'b1, A_CTRL, 32'h1);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, A_CTRL, 32'h0);
`ifdef OTTER_TIMER_PRESCALE_EN
            exp_match = (i >= 9);
`else
            exp_match = (i >= 1);
`endif
            rd(A_STAT, got); n_total++;
            if (got !== {31'd0, exp_match}) $display("FAIL pre_match[%0d]: got %h expected %h", i, got, {31'd0, exp_match});
            else n_pass++;
            rd(A_CNT, got); n_total++;
            if (got !== mread(A_CNT)) $display("FAIL pre_count[%0d]: got %h expected %h", i, got, mread(A_CNT));
            else n_pass++;
        end
        rd(A_CTRL, got); n_total++;
        if (got !== 32'd0) $display("FAIL oneshot_en: got %h expected %h", got, 32'd0);
        else n_pass++;
        rd(A_CNT, got); n_total++;
        if (got !== 32'd1) $display("FAIL oneshot_hold: got %h expected %h", got, 32'd1);
        else n_pass++;
        cycle(1'b1, A_STAT, 32'h1);
    endtask

    task automatic test_w1c_race();
        logic [31:0] got;
        cycle(1'b1, A_PRE, 32'h0);
        cycle(1'b1, A_CMP, 32'h2);
        cycle(1'b1, A_CNT, 32'h0);
        cycle(1'b1, A_CTRL, 32'h5);
        cycle(1'b0, A_CTRL, 32'h0);
        cycle(1'b0, A_CTRL, 32'h0);
        cycle(1'b1, A_STAT, 32'h1);
        rd(A_STAT, got); n_total++;
        if (got !== 32'd1) $display("FAIL w1c_race: got %h expected %h", got, 32'd1);
        else n_pass++;
        cycle(1'b0, A_CTRL, 32'h0);
        n_total++;
        if (bus.INTR !== 1'b1) $display("FAIL w1c_intr_rise: got %b expected 1", bus.INTR);
        else n_pass++;
        cycle(1'b1, A_CTRL, 32'h0);
        cycle(1'b0, A_CTRL, 32'h0);
        rd(A_STAT, got); n_total++;
        if (bus.INTR !== 1'b0 || got !== 32'd1) $display("FAIL ie_clear: got intr %b status %h expected 0 1", bus.INTR, got);
        else n_pass++;
        cycle(1'b1, A_CTRL, 32'h4);
        cycle(1'b1, A_STAT, 32'h1);
        rd(A_STAT, got); n_total++;
        if (got !== 32'd0 || bus.INTR !== 1'b1) $display("FAIL w1c_clear: got status %h intr %b expected 0 1", got, bus.INTR);
        else n_pass++;
        cycle(1'b0, A_CTRL, 32'h0);
        n_total++;
        if (bus.INTR !== 1'b0) $display("FAIL w1c_intr_fall: got %b expected 0", bus.INTR);
        else n_pass++;
    endtask

    task automatic test_wrap_priority();
        logic [31:0] got;
        cycle(1'b1, A_CTRL, 32'h0);
        cycle(1'b1, A_CMP, 32'h5);
        cycle(1'b1, A_CNT, 32'hFFFF_FFFF);
        cycle(1'b1, A_CTRL, 32'h1);
        cycle(1'b0, A_CTRL, 32'h0);
        rd(A_CNT, got); n_total++;
        if (got !== 32'd0) $display("FAIL wrap: got %h expected %h", got, 32'd0);
        else n_pass++;
        cycle(1'b0, A_CTRL, 32'h0);
        cycle(1'b1, A_CNT, 32'h10);
        rd(A_CNT, got); n_total++;
        if (got !== 32'h10) $display("FAIL write_wins: got %h expected %h", got, 32'h10);
        else n_pass++;
        cycle(1'b1, A_CTRL, 32'h0);
    endtask

    task automatic test_decode();
        logic [31:0] got;
        logic [31:0] bad [3] = '{32'h1100_0074, 32'h1100_0020, 32'h1100_0061};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, bad[i], 32'hDEAD);
            rd(bad[i], got); n_total++;
            if (got !== 32'd0) $display("FAIL decode_rd %h: got %h expected %h", bad[i], got, 32'd0);
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            rd(reg_addr[i], got); n_total++;
            if (got !== mread(reg_addr[i])) $display("FAIL decode_reg %h: got %h expected %h", reg_addr[i], got, mread(reg_addr[i]));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] got, a, d;
        int k;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                k = $urandom_range(0, 6);
                a = (k < 5) ? reg_addr[k] : ((k == 5) ? 32'h1100_0074 : 32'h1100_0062);
                case (k)
                    0:       d = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
                    2:       d = 32'($urandom_range(0, 3));
                    3:       d = 32'($urandom_range(0, 6));
                    4:       d = 32'($urandom_range(0, 8));
                    default: d = $urandom;
                endcase
                cycle(1'b1, a, d);
            end else begin
                cycle(1'b0, A_CTRL, 32'h0);
            end
            k = $urandom_range(0, 4);
            rd(reg_addr[k], got); n_total++;
            if (got !== mread(reg_addr[k]) || bus.INTR !== m_intr)
                $display("FAIL random[%0d] reg %h: got %h/%b expected %h/%b", i, reg_addr[k], got, bus.INTR, mread(reg_addr[k]), m_intr);
            else n_pass++;
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.IOBUS_WR = 1'b0; bus.IOBUS_ADDR = 32'd0; bus.IOBUS_OUT = 32'd0;
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        test_reset();
        test_auto_reload();
        test_prescale();
        test_w1c_race();
        test_wrap_priority();
        test_decode();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
